// File: rtl/vector_decode_stage_if.sv
// Signal bundle between fetch, writeback, the decode stage and execute.
//   slave  : the decode stage (consumes fetch/writeback, produces the ID/EX register)
//   master : the environment around it (fetch, writeback and execute side)
// Contents:
//   fetch     : inValid, inReady, instruction, flush
//   writeback : wbScalarEnable, wbVectorEnable, wbAddress, wbScalarData, wbVectorData
//   execute   : outValid, outReady, opcode, mode, illegal, register addresses,
//               scalar/vector operand contents, inmediate
interface vector_decode_stage_if #(
  parameter int SCALAR_DATA_WIDTH = 48,
  parameter int VECTOR_DATA_WIDTH = 8,
  parameter int VECTOR_SIZE       = 6,
  parameter int ADDRESS_WIDTH     = 4,
  parameter int OPCODE_WIDTH      = 4,
  parameter int INSTRUCTION_WIDTH = 48
) ();
  logic                                             inValid;
  logic                                             inReady;
  logic [INSTRUCTION_WIDTH-1:0]                     instruction;
  logic                                             flush;

  logic                                             wbScalarEnable;
  logic                                             wbVectorEnable;
  logic [ADDRESS_WIDTH-1:0]                         wbAddress;
  logic [SCALAR_DATA_WIDTH-1:0]                     wbScalarData;
  logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]    wbVectorData;

  logic                                             outValid;
  logic                                             outReady;
  logic [OPCODE_WIDTH-1:0]                          opcode;
  logic [1:0]                                       mode;
  logic                                             illegal;
  logic [ADDRESS_WIDTH-1:0]                         regDestinationAddress;
  logic [ADDRESS_WIDTH-1:0]                         reg1Address;
  logic [ADDRESS_WIDTH-1:0]                         reg2Address;
  logic [SCALAR_DATA_WIDTH-1:0]                     reg1ScalarContent;
  logic [SCALAR_DATA_WIDTH-1:0]                     reg2ScalarContent;
  logic [SCALAR_DATA_WIDTH-1:0]                     inmediate;
  logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]    reg1VectorContent;
  logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]    reg2VectorContent;

  modport slave (
    input  inValid, instruction, flush,
    input  wbScalarEnable, wbVectorEnable, wbAddress, wbScalarData, wbVectorData,
    input  outReady,
    output inReady,
    output outValid, opcode, mode, illegal,
    output regDestinationAddress, reg1Address, reg2Address,
    output reg1ScalarContent, reg2ScalarContent, inmediate,
    output reg1VectorContent, reg2VectorContent
  );

  modport master (
    output inValid, instruction, flush,
    output wbScalarEnable, wbVectorEnable, wbAddress, wbScalarData, wbVectorData,
    output outReady,
    input  inReady,
    input  outValid, opcode, mode, illegal,
    input  regDestinationAddress, reg1Address, reg2Address,
    input  reg1ScalarContent, reg2ScalarContent, inmediate,
    input  reg1VectorContent, reg2VectorContent
  );
endinterface

// File: rtl/vector_decode_stage.sv
// Decode stage for the scalar/vector CPU.
// Decodes the fetched instruction, reads the scalar and vector register files
// (with writeback bypass and scalar-to-lane broadcast), stalls on RAW hazards
// tracked by a per-register pending scoreboard, and presents the result in a
// registered ID/EX output with a valid/ready handshake.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : vector_decode_stage_if.slave (fetch, writeback and execute signals)
module vector_decode_stage #(
  parameter int                      SCALAR_DATA_WIDTH = 48,
  parameter int                      VECTOR_DATA_WIDTH = 8,
  parameter int                      VECTOR_SIZE       = 6,
  parameter int                      REGNUM            = 16,
  parameter int                      ADDRESS_WIDTH     = 4,
  parameter int                      OPCODE_WIDTH      = 4,
  parameter int                      INSTRUCTION_WIDTH = 48,
  parameter logic [OPCODE_WIDTH-1:0] NOP_OPCODE        = 4'hF
) (
  input  logic                  clock,
  input  logic                  reset,
  vector_decode_stage_if.slave  bus
);

  localparam int OP_LSB   = INSTRUCTION_WIDTH - OPCODE_WIDTH;
  localparam int RD_LSB   = OP_LSB - ADDRESS_WIDTH;
  localparam int RS1_LSB  = RD_LSB - ADDRESS_WIDTH;
  localparam int RS2_LSB  = RS1_LSB - ADDRESS_WIDTH;
  localparam int MODE_LSB = RS2_LSB - 2;

  localparam logic [1:0] MODE_SCALAR  = 2'b00;
  localparam logic [1:0] MODE_VV      = 2'b01;
  localparam logic [1:0] MODE_VS      = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  typedef logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0] vec_t;

  logic [OPCODE_WIDTH-1:0]  in_op;
  logic [ADDRESS_WIDTH-1:0] in_rd, in_rs1, in_rs2;
  logic [1:0]               in_mode;
  logic                     unused_fields;

  assign in_op   = bus.instruction[OP_LSB   +: OPCODE_WIDTH];
  assign in_rd   = bus.instruction[RD_LSB   +: ADDRESS_WIDTH];
  assign in_rs1  = bus.instruction[RS1_LSB  +: ADDRESS_WIDTH];
  assign in_rs2  = bus.instruction[RS2_LSB  +: ADDRESS_WIDTH];
  assign in_mode = bus.instruction[MODE_LSB +: 2];
  assign unused_fields = ^bus.instruction[MODE_LSB-1:16];

  // Register files
  logic [SCALAR_DATA_WIDTH-1:0] sreg [REGNUM];
  vec_t                         vreg [REGNUM];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REGNUM; i++) begin
        sreg[i] <= '0;
        vreg[i] <= '0;
      end
    end else begin
      if (bus.wbScalarEnable) sreg[bus.wbAddress] <= bus.wbScalarData;
      if (bus.wbVectorEnable) vreg[bus.wbAddress] <= bus.wbVectorData;
    end
  end

  // Reads with bypass of the value being written this cycle
  logic [SCALAR_DATA_WIDTH-1:0] s1_rd, s2_rd;
  vec_t                         v1_rd, v2_rd, v2_bc;

  assign s1_rd = (bus.wbScalarEnable && bus.wbAddress == in_rs1) ? bus.wbScalarData : sreg[in_rs1];
  assign s2_rd = (bus.wbScalarEnable && bus.wbAddress == in_rs2) ? bus.wbScalarData : sreg[in_rs2];
  assign v1_rd = (bus.wbVectorEnable && bus.wbAddress == in_rs1) ? bus.wbVectorData : vreg[in_rs1];
  assign v2_rd = (bus.wbVectorEnable && bus.wbAddress == in_rs2) ? bus.wbVectorData : vreg[in_rs2];

  always_comb begin
    v2_bc = '0;
    for (int l = 0; l < VECTOR_SIZE; l++) v2_bc[l] = s2_rd[VECTOR_DATA_WIDTH-1:0];
  end

  // Hazard detection
  logic [REGNUM-1:0] pend_s, pend_v;
  logic              in_active, rs1_vec, rs2_vec;
  logic              out_dest, out_dest_vec, hazard, transfer;

  function automatic logic src_busy(
    input logic                     is_vec,
    input logic [ADDRESS_WIDTH-1:0] a,
    input logic [REGNUM-1:0]        ps,
    input logic [REGNUM-1:0]        pv,
    input logic                     ws,
    input logic                     wv,
    input logic [ADDRESS_WIDTH-1:0] wa,
    input logic                     od,
    input logic                     odv,
    input logic [ADDRESS_WIDTH-1:0] ord
  );
    logic pend, clr;
    pend = is_vec ? pv[a] : ps[a];
    clr  = (is_vec ? wv : ws) && (wa == a);
    // The instruction sitting in the output register is not yet in the
    // scoreboard, so it is checked directly.
    return (pend && !clr) || (od && (odv == is_vec) && (ord == a));
  endfunction

  assign in_active    = (in_op != NOP_OPCODE) && (in_mode != MODE_ILLEGAL);
  assign rs1_vec      = (in_mode != MODE_SCALAR);
  assign rs2_vec      = (in_mode == MODE_VV);
  assign out_dest     = bus.outValid && (bus.opcode != NOP_OPCODE) && (bus.mode != MODE_ILLEGAL);
  assign out_dest_vec = (bus.mode != MODE_SCALAR);

  assign hazard = in_active &&
    (src_busy(rs1_vec, in_rs1, pend_s, pend_v, bus.wbScalarEnable, bus.wbVectorEnable,
              bus.wbAddress, out_dest, out_dest_vec, bus.regDestinationAddress) ||
     src_busy(rs2_vec, in_rs2, pend_s, pend_v, bus.wbScalarEnable, bus.wbVectorEnable,
              bus.wbAddress, out_dest, out_dest_vec, bus.regDestinationAddress));

  assign bus.inReady = !hazard && (!bus.outValid || bus.outReady) && !bus.flush;
  assign transfer    = bus.inValid && bus.inReady;

  // Scoreboard: set when a destination leaves toward execute, cleared by
  // writeback; the set term is applied last so it wins a same-cycle collision.
  logic              issue_dest;
  logic [REGNUM-1:0] set_s, set_v, clr_s, clr_v;

  assign issue_dest = out_dest && bus.outReady && !bus.flush;

  always_comb begin
    set_s = '0;
    set_v = '0;
    clr_s = '0;
    clr_v = '0;
    for (int i = 0; i < REGNUM; i++) begin
      clr_s[i] = bus.wbScalarEnable && (bus.wbAddress == ADDRESS_WIDTH'(i));
      clr_v[i] = bus.wbVectorEnable && (bus.wbAddress == ADDRESS_WIDTH'(i));
      set_s[i] = issue_dest && !out_dest_vec && (bus.regDestinationAddress == ADDRESS_WIDTH'(i));
      set_v[i] = issue_dest &&  out_dest_vec && (bus.regDestinationAddress == ADDRESS_WIDTH'(i));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_s <= '0;
      pend_v <= '0;
    end else begin
      pend_s <= (pend_s & ~clr_s) | set_s;
      pend_v <= (pend_v & ~clr_v) | set_v;
    end
  end

  // ID/EX output register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.outValid              <= 1'b0;
      bus.opcode                <= '0;
      bus.mode                  <= '0;
      bus.illegal               <= 1'b0;
      bus.regDestinationAddress <= '0;
      bus.reg1Address           <= '0;
      bus.reg2Address           <= '0;
      bus.reg1ScalarContent     <= '0;
      bus.reg2ScalarContent     <= '0;
      bus.inmediate             <= '0;
      bus.reg1VectorContent     <= '0;
      bus.reg2VectorContent     <= '0;
    end else if (bus.flush) begin
      bus.outValid <= 1'b0;
    end else if (transfer) begin
      bus.outValid              <= 1'b1;
      bus.opcode                <= in_op;
      bus.mode                  <= in_mode;
      bus.illegal               <= (in_mode == MODE_ILLEGAL);
      bus.regDestinationAddress <= in_rd;
      bus.reg1Address           <= in_rs1;
      bus.reg2Address           <= in_rs2;
      bus.reg1ScalarContent     <= s1_rd;
      bus.reg2ScalarContent     <= s2_rd;
      bus.inmediate             <= SCALAR_DATA_WIDTH'(bus.instruction[15:0]);
      bus.reg1VectorContent     <= v1_rd;
      bus.reg2VectorContent     <= (in_mode == MODE_VS) ? v2_bc : v2_rd;
    end else if (bus.outReady) begin
      bus.outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vector_decode_stage.sv
// Bench for vector_decode_stage: directed scenarios followed by random traffic,
// all predicted by a behavioural model; a monitor compares the ID/EX register
// against a queue of expected instructions.
module tb_vector_decode_stage;

  typedef logic [5:0][7:0] vec_t;

  typedef struct {
    logic [3:0]  op, rd, r1, r2;
    logic [1:0]  md;
    logic        ill;
    logic [47:0] s1, s2, imm;
    vec_t        v1, v2;
  } exp_t;

  typedef struct {
    bit         f;
    logic [3:0] a;
  } dst_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  vector_decode_stage_if #(
    .SCALAR_DATA_WIDTH(48), .VECTOR_DATA_WIDTH(8), .VECTOR_SIZE(6),
    .ADDRESS_WIDTH(4), .OPCODE_WIDTH(4), .INSTRUCTION_WIDTH(48)
  ) bus ();

  vector_decode_stage #(
    .SCALAR_DATA_WIDTH(48), .VECTOR_DATA_WIDTH(8), .VECTOR_SIZE(6), .REGNUM(16),
    .ADDRESS_WIDTH(4), .OPCODE_WIDTH(4), .INSTRUCTION_WIDTH(48), .NOP_OPCODE(4'hF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [47:0] m_sreg [16];
  vec_t        m_vreg [16];
  bit          m_pend [2][16];
  bit          m_ov;
  exp_t        m_out;
  exp_t        exp_q [$];
  dst_t        infl [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit writes_reg(input logic [3:0] op, input logic [1:0] md);
    return (op != 4'hF) && (md != 2'd3);
  endfunction

  function automatic logic [47:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] r1, input logic [3:0] r2,
                                     input logic [1:0] md, input logic [15:0] imm);
    return {op, rd, r1, r2, md, 14'h2A5B, imm};
  endfunction

  function automatic logic [47:0] sval(input int i);
    if (i == 2) return 48'h123456789AAB;
    return 48'h5A0000000000 | (48'(i) << 24) | 48'(i * 7 + 1);
  endfunction

  function automatic vec_t vval(input int i);
    vec_t v;
    for (int l = 0; l < 6; l++) v[l] = 8'(i * 16 + l + 1);
    return v;
  endfunction

  // A source register is blocked if its file marks it in flight (and this
  // cycle's writeback does not retire it) or the instruction waiting in the
  // output register is about to produce it.
  function automatic bit blocked(input bit f, input logic [3:0] a, input bit ws, input bit wv,
                                 input logic [3:0] wa);
    bit retiring;
    retiring = (f ? wv : ws) && (wa == a);
    if (m_pend[f][a] && !retiring) return 1'b1;
    if (m_ov && writes_reg(m_out.op, m_out.md) && ((m_out.md != 2'd0) == f) && (m_out.rd == a))
      return 1'b1;
    return 1'b0;
  endfunction

  function automatic vec_t rd_v(input logic [3:0] a, input bit wv, input logic [3:0] wa, input vec_t vd);
    return (wv && wa == a) ? vd : m_vreg[a];
  endfunction

  function automatic logic [47:0] rd_s(input logic [3:0] a, input bit ws, input logic [3:0] wa,
                                      input logic [47:0] sd);
    return (ws && wa == a) ? sd : m_sreg[a];
  endfunction

  // One clock cycle: called right after a falling edge, returns after the next one.
  task automatic step(input bit iv, input logic [47:0] ins, input bit fl, input bit ordy,
                      input bit ws, input bit wv, input logic [3:0] wa,
                      input logic [47:0] sd, input vec_t vd, output bit acc);
    exp_t e, drop;
    bit haz, rdy, hs;
    logic [3:0] op, rd, r1, r2;
    logic [1:0] md;
    bus.inValid        = iv;
    bus.instruction    = ins;
    bus.flush          = fl;
    bus.outReady       = ordy;
    bus.wbScalarEnable = ws;
    bus.wbVectorEnable = wv;
    bus.wbAddress      = wa;
    bus.wbScalarData   = sd;
    bus.wbVectorData   = vd;
    #4;
    op = ins[47:44]; rd = ins[43:40]; r1 = ins[39:36]; r2 = ins[35:32]; md = ins[31:30];
    haz = 1'b0;
    if (writes_reg(op, md))
      haz = blocked(md != 2'd0, r1, ws, wv, wa) || blocked(md == 2'd1, r2, ws, wv, wa);
    rdy = !haz && (!m_ov || ordy) && !fl;
    chk("inReady", 64'(bus.inReady), 64'(rdy));
    chk("outValid", 64'(bus.outValid), 64'(m_ov));
    acc = iv && rdy;
    hs  = m_ov && ordy && !fl;
    e = m_out;
    if (acc) begin
      e.op  = op; e.rd = rd; e.r1 = r1; e.r2 = r2; e.md = md;
      e.ill = (md == 2'd3);
      e.s1  = rd_s(r1, ws, wa, sd);
      e.s2  = rd_s(r2, ws, wa, sd);
      e.imm = {32'h0, ins[15:0]};
      e.v1  = rd_v(r1, wv, wa, vd);
      e.v2  = (md == 2'd2) ? {6{e.s2[7:0]}} : rd_v(r2, wv, wa, vd);
      exp_q.push_back(e);
    end
    if (fl && m_ov && exp_q.size() > 0) drop = exp_q.pop_front();
    // model state after the rising edge
    if (ws) begin m_sreg[wa] = sd; m_pend[0][wa] = 1'b0; end
    if (wv) begin m_vreg[wa] = vd; m_pend[1][wa] = 1'b0; end
    if (hs && writes_reg(m_out.op, m_out.md)) begin
      m_pend[m_out.md != 2'd0][m_out.rd] = 1'b1;
      infl.push_back('{f: (m_out.md != 2'd0), a: m_out.rd});
    end
    if (fl) m_ov = 1'b0;
    else if (acc) begin m_ov = 1'b1; m_out = e; end
    else if (ordy) m_ov = 1'b0;
    @(negedge clock);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_sreg[i] = '0; m_vreg[i] = '0; m_pend[0][i] = 1'b0; m_pend[1][i] = 1'b0;
    end
    m_ov = 1'b0;
    m_out = '{default: '0};
    exp_q.delete();
    infl.delete();
  endtask

  task automatic set_idle();
    bus.inValid = 1'b0; bus.instruction = '0; bus.flush = 1'b0; bus.outReady = 1'b1;
    bus.wbScalarEnable = 1'b0; bus.wbVectorEnable = 1'b0; bus.wbAddress = '0;
    bus.wbScalarData = '0; bus.wbVectorData = '0;
  endtask

  task automatic check_zero_outputs();
    chk("rst outValid", 64'(bus.outValid), 64'(0));
    chk("rst opcode", 64'(bus.opcode), 64'(0));
    chk("rst mode", 64'(bus.mode), 64'(0));
    chk("rst illegal", 64'(bus.illegal), 64'(0));
    chk("rst rd", 64'(bus.regDestinationAddress), 64'(0));
    chk("rst rs1", 64'(bus.reg1Address), 64'(0));
    chk("rst rs2", 64'(bus.reg2Address), 64'(0));
    chk("rst s1", 64'(bus.reg1ScalarContent), 64'(0));
    chk("rst s2", 64'(bus.reg2ScalarContent), 64'(0));
    chk("rst imm", 64'(bus.inmediate), 64'(0));
    chk("rst v1", 64'(bus.reg1VectorContent), 64'(0));
    chk("rst v2", 64'(bus.reg2VectorContent), 64'(0));
    chk("rst inReady", 64'(bus.inReady), 64'(1));
  endtask

  // Monitor: compare the presented output with the head of the queue, retire on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #4;
      if (reset && bus.outValid && !bus.flush) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected outValid: got opcode %0h with nothing expected", bus.opcode);
        end else begin
          e = exp_q[0];
          chk("opcode", 64'(bus.opcode), 64'(e.op));
          chk("mode", 64'(bus.mode), 64'(e.md));
          chk("illegal", 64'(bus.illegal), 64'(e.ill));
          chk("rd", 64'(bus.regDestinationAddress), 64'(e.rd));
          chk("rs1", 64'(bus.reg1Address), 64'(e.r1));
          chk("rs2", 64'(bus.reg2Address), 64'(e.r2));
          chk("reg1Scalar", 64'(bus.reg1ScalarContent), 64'(e.s1));
          chk("reg2Scalar", 64'(bus.reg2ScalarContent), 64'(e.s2));
          chk("inmediate", 64'(bus.inmediate), 64'(e.imm));
          chk("reg1Vector", 64'(bus.reg1VectorContent), 64'(e.v1));
          chk("reg2Vector", 64'(bus.reg2VectorContent), 64'(e.v2));
          if (bus.outReady) e = exp_q.pop_front();
        end
      end
    end
  end

  initial begin
    bit a, have, ws, wv, fl, ordy;
    logic [3:0] wa;
    logic [47:0] cur, sd;
    vec_t vd, zv;
    dst_t d;
    int idx;

    zv = '0;
    set_idle();
    model_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 check_zero_outputs();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // preload both register files
    for (int i = 0; i < 16; i++) step(0, '0, 0, 1, 1, 0, 4'(i), sval(i), zv, a);
    for (int i = 0; i < 16; i++) step(0, '0, 0, 1, 0, 1, 4'(i), '0, vval(i), a);

    // back-to-back independent scalar ops
    for (int k = 0; k < 4; k++)
      step(1, mk(4'h1, 4'(8 + k), 4'(2 * k), 4'(2 * k + 1), 2'd0, 16'(16'h1000 + k)), 0, 1, 0, 0, '0, '0, zv, a);
    step(0, '0, 0, 1, 0, 0, '0, '0, zv, a);
    for (int k = 0; k < 4; k++) step(0, '0, 0, 1, 1, 0, 4'(8 + k), sval(8 + k), zv, a);

    // RAW on S3: stall until the writeback, which is bypassed
    step(1, mk(4'h2, 4'd3, 4'd0, 4'd1, 2'd0, 16'h0003), 0, 1, 0, 0, '0, '0, zv, a);
    for (int c = 0; c < 3; c++) step(1, mk(4'h3, 4'd12, 4'd3, 4'd4, 2'd0, 16'hBEEF), 0, 1, 0, 0, '0, '0, zv, a);
    step(1, mk(4'h3, 4'd12, 4'd3, 4'd4, 2'd0, 16'hBEEF), 0, 1, 1, 0, 4'd3, 48'h0000DEADBEEF, zv, a);
    step(0, '0, 0, 1, 0, 0, '0, '0, zv, a);
    step(0, '0, 0, 1, 1, 0, 4'd12, 48'h777, zv, a);

    // vector-scalar broadcast of S2's low byte
    step(1, mk(4'h4, 4'd6, 4'd4, 4'd2, 2'd2, 16'h00AB), 0, 1, 0, 0, '0, '0, zv, a);
    step(0, '0, 0, 1, 0, 0, '0, '0, zv, a);
    step(0, '0, 0, 1, 0, 1, 4'd6, '0, vval(9), a);

    // execute back-pressure for three cycles
    step(1, mk(4'h5, 4'd13, 4'd0, 4'd1, 2'd0, 16'h0005), 0, 1, 0, 0, '0, '0, zv, a);
    for (int c = 0; c < 3; c++) step(1, mk(4'h6, 4'd14, 4'd0, 4'd1, 2'd0, 16'h0006), 0, 0, 0, 0, '0, '0, zv, a);
    step(1, mk(4'h6, 4'd14, 4'd0, 4'd1, 2'd0, 16'h0006), 0, 1, 0, 0, '0, '0, zv, a);
    step(0, '0, 0, 1, 0, 0, '0, '0, zv, a);

    // issue to V5 in the same cycle V5 is written back: V5 stays in flight
    step(1, mk(4'h7, 4'd5, 4'd0, 4'd1, 2'd1, 16'h0007), 0, 1, 0, 0, '0, '0, zv, a);
    step(0, '0, 0, 1, 0, 1, 4'd5, '0, vval(11), a);
    for (int c = 0; c < 2; c++) step(1, mk(4'h8, 4'd7, 4'd5, 4'd1, 2'd1, 16'h0008), 0, 1, 0, 0, '0, '0, zv, a);
    step(1, mk(4'h8, 4'd7, 4'd5, 4'd1, 2'd1, 16'h0008), 0, 1, 0, 1, 4'd5, '0, vval(12), a);
    step(0, '0, 0, 1, 0, 0, '0, '0, zv, a);

    // flush squashes the output; S9 must not become pending
    step(1, mk(4'h9, 4'd9, 4'd0, 4'd1, 2'd0, 16'h0009), 0, 1, 0, 0, '0, '0, zv, a);
    step(0, '0, 1, 0, 0, 0, '0, '0, zv, a);
    step(1, mk(4'hA, 4'd10, 4'd9, 4'd0, 2'd0, 16'h000A), 0, 1, 0, 0, '0, '0, zv, a);
    step(0, '0, 0, 1, 0, 0, '0, '0, zv, a);

    // reset in the middle of a stall
    step(1, mk(4'hB, 4'd7, 4'd0, 4'd1, 2'd0, 16'h000B), 0, 1, 0, 0, '0, '0, zv, a);
    for (int c = 0; c < 2; c++) step(1, mk(4'hC, 4'd8, 4'd7, 4'd0, 2'd0, 16'h000C), 0, 1, 0, 0, '0, '0, zv, a);
    #2;
    set_idle();
    reset = 1'b0;
    #1 check_zero_outputs();
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    step(1, mk(4'hC, 4'd8, 4'd7, 4'd0, 2'd0, 16'h000C), 0, 1, 0, 0, '0, '0, zv, a);
    step(0, '0, 0, 1, 0, 0, '0, '0, zv, a);

    // mode 11: illegal, and it must not mark S4 in flight
    step(1, mk(4'hD, 4'd4, 4'd5, 4'd6, 2'd3, 16'h000D), 0, 1, 0, 0, '0, '0, zv, a);
    step(0, '0, 0, 1, 0, 0, '0, '0, zv, a);
    step(1, mk(4'h1, 4'd1, 4'd4, 4'd4, 2'd0, 16'h0001), 0, 1, 0, 0, '0, '0, zv, a);
    step(0, '0, 0, 1, 0, 0, '0, '0, zv, a);

    // random traffic
    have = 1'b0;
    cur  = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!have && $urandom_range(0, 4) != 0) begin
        cur = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)),
               ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
               14'($urandom()), 16'($urandom())};
        have = 1'b1;
      end
      ws = 1'b0; wv = 1'b0; wa = '0;
      sd = 48'({$urandom(), $urandom()});
      vd = 48'({$urandom(), $urandom()});
      if (infl.size() > 0 && $urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, infl.size() - 1);
        d = infl[idx];
        infl.delete(idx);
        if (d.f) wv = 1'b1; else ws = 1'b1;
        wa = d.a;
      end else if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 1) == 0) ws = 1'b1; else wv = 1'b1;
        wa = 4'($urandom_range(0, 15));
      end
      fl   = ($urandom_range(0, 24) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      step(have, cur, fl, ordy, ws, wv, wa, sd, vd, a);
      if (a) have = 1'b0;
    end

    for (int c = 0; c < 3; c++) step(0, '0, 0, 1, 0, 0, '0, '0, zv, a);
    chk("expected queue drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
